ad9361_rx_deframer: RTL and testbench
=====================================

# ad9361_rx_deframer

Recovers 12-bit I/Q samples from the AD9361 6-bit framed receive data stream: two 6-bit words (MSB word first) per 12-bit sample, with a frame marker. It sits between the receive-side data capture stage and the ADC channel datapath. The block aligns to the frame marker, verifies frame periodicity before declaring lock, and counts alignment errors. It runs in both 1R1T and 2R2T modes.

## Interface
Parameters:
- LOCK_COUNT, 4, consecutive error-free frame periods required in VERIFY before LOCKED (range 1..15)
- ERR_WIDTH, 16, width of the saturating alignment-error counter

Ports:
- clk  input  1  interface clock, one 6-bit word per rising edge
- rst  input  1  reset, asynchronous, active-high
- enable  input  1  deframer enable; low forces SEARCH
- r1_mode  input  1  1 = 1R1T (period P=4 words), 0 = 2R2T (P=8 words)
- rx_frame  input  1  frame marker, sampled with rx_data
- rx_data  input  6  data word
- adc_valid  output  1  one-cycle strobe, new sample set on adc_data_*
- adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1  output  12 each  recovered samples (i1/q1 are 0 in 1R1T)
- adc_locked  output  1  high in LOCKED state
- adc_err_count  output  ERR_WIDTH  saturating count of alignment errors detected while LOCKED

## Operation
- Input stage: rx_frame, rx_data, r1_mode are registered (stage 1); all decoding uses stage-1 values. frame_rise = stage-1 frame high while the previous stage-1 frame was low.
- Word index cnt (0..P-1): frame_rise loads cnt=0 for that word; otherwise cnt increments and wraps P-1 -> 0.
- Expected frame level: 1R1T high for w0-w1, low for w2-w3; 2R2T high for w0-w3, low for w4-w7.
- Alignment error (checked in VERIFY/LOCKED): frame_rise at cnt_expected != 0, or stage-1 frame level != expected level for the current word.
- Assembly: 1R1T i0={w0,w1}, q0={w2,w3}. 2R2T additionally i1={w4,w5}, q1={w6,w7}. w0 is the high 6 bits.
- States:
  - SEARCH: wait for frame_rise. On frame_rise go to VERIFY with good=0 and cnt aligned.
  - VERIFY: each period completed without error increments good. When good reaches LOCK_COUNT, go to LOCKED. Any error returns to SEARCH; err_count is unchanged.
  - LOCKED: on error go to SEARCH and increment err_count (saturating at all-ones).
- enable low, or any change of the stage-1 r1_mode: go to SEARCH on the next edge and clear good. err_count is not incremented.
- adc_valid is asserted only for periods completed in LOCKED with no error on any word. A period containing an error produces no strobe.
- adc_data_* hold their last value between strobes. i1/q1 are driven 0 in 1R1T.

## Timing
- Reset values: adc_valid=0, adc_data_*=0, adc_locked=0, adc_err_count=0, state=SEARCH, cnt=0, good=0. These take effect immediately on rst assertion (asynchronous).
- Latency: the last word of a period on the pins at edge E is registered at E. adc_valid and adc_data_* update at E+1, and adc_valid is high for exactly one cycle.
- Strobe spacing in lock: exactly P cycles.
- adc_locked rises at the edge that completes the LOCK_COUNT-th good period. On an error word registered at edge E, adc_locked falls and err_count increments at E+1.
- Minimum lock time from a clean stream: one partial period in SEARCH, then LOCK_COUNT full periods.
- A frame_rise at the wrap point (cnt=P-1 -> 0) is correct alignment, not an error.
- Reset asserted mid-period discards the partial sample. Operation after release restarts in SEARCH.

## Test plan
- 1R1T, LOCK_COUNT=4, repeating words 0x2A,0x15,0x3F,0x01 with frame 1,1,0,0 -> adc_locked after 4 good periods. adc_valid every 4 cycles with i0=0xA95, q0=0xFC1, i1=q1=0. err_count=0.
- 2R2T, words 0x01..0x08 with frame 1,1,1,1,0,0,0,0 -> valid every 8 cycles with i0=0x042, q0=0x0C4, i1=0x146, q1=0x1C8.
- Locked 1R1T, drop one word (frame high for 1 word only) -> adc_locked low one cycle after the bad word. err_count=1. No strobe for the broken period. Relock after LOCK_COUNT clean periods.
- ERR_WIDTH=2, inject 5 slips, relocking between them -> err_count stops at 3.
- Toggle r1_mode while locked -> SEARCH, adc_locked low, err_count unchanged. Lock is regained in the new mode.
- Assert rst mid-period while locked -> all outputs 0 without waiting for a clock edge. After release, a clean stream relocks in 4 periods.

Source files
------------

// File: rtl/ad9361_rx_deframer_if.sv
// Receive-side bus between the capture stage and the deframer: framed 6-bit words in,
// recovered 12-bit I/Q samples, lock status and error count out.
interface ad9361_rx_deframer_if #(
    parameter int unsigned ERR_WIDTH = 16
);
    localparam int unsigned WORD_W   = 6;
    localparam int unsigned SAMPLE_W = 12;

    logic                 enable;
    logic                 r1_mode;
    logic                 rx_frame;
    logic [WORD_W-1:0]    rx_data;
    logic                 adc_valid;
    logic [SAMPLE_W-1:0]  adc_data_i0;
    logic [SAMPLE_W-1:0]  adc_data_q0;
    logic [SAMPLE_W-1:0]  adc_data_i1;
    logic [SAMPLE_W-1:0]  adc_data_q1;
    logic                 adc_locked;
    logic [ERR_WIDTH-1:0] adc_err_count;

    modport master (
        output enable, r1_mode, rx_frame, rx_data,
        input  adc_valid, adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1,
               adc_locked, adc_err_count
    );

    modport slave (
        input  enable, r1_mode, rx_frame, rx_data,
        output adc_valid, adc_data_i0, adc_data_q0, adc_data_i1, adc_data_q1,
               adc_locked, adc_err_count
    );
endinterface

// File: rtl/ad9361_rx_deframer.sv
// Aligns to the AD9361 receive frame marker, verifies frame periodicity before lock,
// and reassembles 12-bit I/Q samples from pairs of 6-bit words (1R1T and 2R2T).
module ad9361_rx_deframer #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ad9361_rx_deframer_if.slave  bus
);
    localparam int unsigned WORD_W    = 6;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned GOOD_W    = 4;
    localparam int unsigned MAX_WORDS = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                              state;
    logic                                frame_s1;
    logic                                frame_s1_d;
    logic                                mode_s1;
    logic                                mode_s1_d;
    logic [WORD_W-1:0]                   data_s1;
    logic [CNT_W-1:0]                    cnt;
    logic [GOOD_W-1:0]                   good;
    logic [MAX_WORDS-1:0][WORD_W-1:0]    words;
    logic                                valid_q;
    logic [SAMPLE_W-1:0]                 i0_q;
    logic [SAMPLE_W-1:0]                 q0_q;
    logic [SAMPLE_W-1:0]                 i1_q;
    logic [SAMPLE_W-1:0]                 q1_q;
    logic [ERR_WIDTH-1:0]                err_q;

    logic [CNT_W-1:0]                    last_idx;
    logic [CNT_W-1:0]                    cnt_exp;
    logic [CNT_W-1:0]                    cnt_cur;
    logic                                frame_rise;
    logic                                level_exp;
    logic                                align_err;
    logic                                period_end;
    logic                                mode_change;
    logic [GOOD_W-1:0]                   good_inc;
    logic                                lock_reached;

    // Input capture: every decision below is made on these stage-1 copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_s1   <= 1'b0;
            frame_s1_d <= 1'b0;
            mode_s1    <= 1'b0;
            mode_s1_d  <= 1'b0;
            data_s1    <= '0;
        end else begin
            frame_s1   <= bus.rx_frame;
            frame_s1_d <= frame_s1;
            mode_s1    <= bus.r1_mode;
            mode_s1_d  <= mode_s1;
            data_s1    <= bus.rx_data;
        end
    end

    // Word position and alignment check for the stage-1 word.
    always_comb begin
        last_idx     = mode_s1 ? CNT_W'(3) : CNT_W'(7);
        frame_rise   = frame_s1 & ~frame_s1_d;
        cnt_exp      = (cnt >= last_idx) ? CNT_W'(0) : cnt + CNT_W'(1);
        cnt_cur      = frame_rise ? CNT_W'(0) : cnt_exp;
        level_exp    = (cnt_exp < (mode_s1 ? CNT_W'(2) : CNT_W'(4)));
        align_err    = (frame_rise && (cnt_exp != CNT_W'(0))) || (frame_s1 != level_exp);
        period_end   = (cnt_cur == last_idx);
        mode_change  = (mode_s1 != mode_s1_d);
        good_inc     = good + GOOD_W'(1);
        lock_reached = (good_inc == GOOD_W'(LOCK_COUNT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEARCH;
            cnt     <= '0;
            good    <= '0;
            words   <= '0;
            valid_q <= 1'b0;
            i0_q    <= '0;
            q0_q    <= '0;
            i1_q    <= '0;
            q1_q    <= '0;
            err_q   <= '0;
        end else begin
            valid_q        <= 1'b0;
            cnt            <= cnt_cur;
            words[cnt_cur] <= data_s1;
            // Disable or a mode switch is a deliberate restart, not an alignment error.
            if (!bus.enable || mode_change) begin
                state <= SEARCH;
                good  <= '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (frame_rise) begin
                            state <= VERIFY;
                            good  <= '0;
                        end
                    end
                    VERIFY: begin
                        if (align_err) begin
                            state <= SEARCH;
                            good  <= '0;
                        end else if (period_end) begin
                            good <= good_inc;
                            if (lock_reached) state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (align_err) begin
                            state <= SEARCH;
                            good  <= '0;
                            if (err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
                        end else if (period_end) begin
                            // The final word is still in stage 1, so it is taken directly.
                            valid_q <= 1'b1;
                            i0_q    <= {words[0], words[1]};
                            if (mode_s1) begin
                                q0_q <= {words[2], data_s1};
                                i1_q <= '0;
                                q1_q <= '0;
                            end else begin
                                q0_q <= {words[2], words[3]};
                                i1_q <= {words[4], words[5]};
                                q1_q <= {words[6], data_s1};
                            end
                        end
                    end
                    default: begin
                        state <= SEARCH;
                        good  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.adc_valid     = valid_q;
    assign bus.adc_data_i0   = i0_q;
    assign bus.adc_data_q0   = q0_q;
    assign bus.adc_data_i1   = i1_q;
    assign bus.adc_data_q1   = q1_q;
    assign bus.adc_locked    = (state == LOCKED);
    assign bus.adc_err_count = err_q;
endmodule

// File: tb/tb_ad9361_rx_deframer.sv
// Randomised and directed checks of ad9361_rx_deframer against a word-level reference model,
// run on a 16-bit and a 2-bit error-counter instance fed the same stream.
module tb_ad9361_rx_deframer;
    localparam int unsigned LOCK_COUNT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       mode = 1'b1;
    logic       frm = 1'b0;
    logic [5:0] dat = 6'd0;

    int checks = 0;
    int errors = 0;

    ad9361_rx_deframer_if #(.ERR_WIDTH(16)) bus16 ();
    ad9361_rx_deframer_if #(.ERR_WIDTH(2))  bus2 ();

    assign bus16.enable   = en;
    assign bus16.r1_mode  = mode;
    assign bus16.rx_frame = frm;
    assign bus16.rx_data  = dat;
    assign bus2.enable    = en;
    assign bus2.r1_mode   = mode;
    assign bus2.rx_frame  = frm;
    assign bus2.rx_data   = dat;

    ad9361_rx_deframer #(.LOCK_COUNT(LOCK_COUNT), .ERR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    ad9361_rx_deframer #(.LOCK_COUNT(LOCK_COUNT), .ERR_WIDTH(2)) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one word per edge, thought of as "previous word's stage-1 copy" and a period phase.
    bit         m_f, m_fp, m_m, m_mp;
    logic [5:0] m_d;
    logic [5:0] m_w [8];
    int         m_cnt, m_st, m_good, m_errc, m_len, m_nxt, m_cur;
    bit         m_rise, m_bad;
    bit         e_valid;
    logic [11:0] e_i0, e_q0, e_i1, e_q1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_f = 0; m_fp = 0; m_m = 0; m_mp = 0; m_d = 0;
            m_cnt = 0; m_st = 0; m_good = 0; m_errc = 0;
            e_valid = 0; e_i0 = 0; e_q0 = 0; e_i1 = 0; e_q1 = 0;
            for (int i = 0; i < 8; i++) m_w[i] = 0;
        end else begin
            m_len  = m_m ? 4 : 8;
            m_rise = m_f && !m_fp;
            m_nxt  = (m_cnt + 1) % m_len;
            m_cur  = m_rise ? 0 : m_nxt;
            m_bad  = (m_rise && m_nxt != 0) || (m_f != (m_nxt < m_len / 2));
            m_w[m_cur] = m_d;
            m_cnt   = m_cur;
            e_valid = 0;
            if (!en || m_m != m_mp) begin
                m_st = 0; m_good = 0;
            end else if (m_st == 0) begin
                if (m_rise) begin m_st = 1; m_good = 0; end
            end else if (m_bad) begin
                if (m_st == 2) m_errc++;
                m_st = 0; m_good = 0;
            end else if (m_cur == m_len - 1) begin
                if (m_st == 1) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) m_st = 2;
                end else begin
                    e_valid = 1;
                    e_i0 = {m_w[0], m_w[1]};
                    e_q0 = {m_w[2], m_w[3]};
                    e_i1 = (m_len == 8) ? {m_w[4], m_w[5]} : 12'h000;
                    e_q1 = (m_len == 8) ? {m_w[6], m_w[7]} : 12'h000;
                end
            end
            m_fp = m_f; m_mp = m_m;
            m_f = frm; m_m = mode; m_d = dat;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 32'(bus16.adc_valid), 32'(e_valid));
            chk("locked", 32'(bus16.adc_locked), 32'(m_st == 2));
            chk("err16", 32'(bus16.adc_err_count), 32'(m_errc));
            chk("data", {bus16.adc_data_i0, bus16.adc_data_q0, 8'h00}, {e_i0, e_q0, 8'h00});
            chk("data1", {bus16.adc_data_i1, bus16.adc_data_q1, 8'h00}, {e_i1, e_q1, 8'h00});
            chk("w2_err", 32'(bus2.adc_err_count), 32'((m_errc > 3) ? 3 : m_errc));
            chk("w2_valid_locked", {30'd0, bus2.adc_valid, bus2.adc_locked}, {30'd0, e_valid, m_st == 2});
        end
    end

    int ph = 0;
    bit rand_data = 0;

    function automatic logic [5:0] pat(input bit m, input int idx);
        logic [5:0] t1 [4];
        t1[0] = 6'h2A; t1[1] = 6'h15; t1[2] = 6'h3F; t1[3] = 6'h01;
        return m ? t1[idx % 4] : 6'(idx + 1);
    endfunction

    task automatic send_word(input bit f, input logic [5:0] d);
        frm = f;
        dat = d;
        @(negedge clk);
    endtask

    task automatic clean(input int n);
        int len;
        for (int i = 0; i < n; i++) begin
            len = mode ? 4 : 8;
            send_word(ph < len / 2, rand_data ? 6'($urandom_range(0, 63)) : pat(mode, ph));
            ph = (ph + 1) % len;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus16.adc_valid), 32'd0);
        chk({tag, "_locked"}, 32'(bus16.adc_locked), 32'd0);
        chk({tag, "_err"}, 32'(bus16.adc_err_count), 32'd0);
        chk({tag, "_data"}, {8'h00, bus16.adc_data_i0, bus16.adc_data_q0},  32'd0);
        chk({tag, "_data1"}, {8'h00, bus16.adc_data_i1, bus16.adc_data_q1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // 1R1T lock from a mid-period start: 2 partial words, then 4 full periods.
        mode = 1'b1; ph = 2;
        clean(18);
        chk("lock_early", 32'(bus16.adc_locked), 32'd0);
        clean(1);
        chk("lock_on_time", 32'(bus16.adc_locked), 32'd1);
        clean(8);
        chk("r1_valid", 32'(bus16.adc_valid), 32'd1);
        chk("r1_i0", 32'(bus16.adc_data_i0), 32'h0A95);
        chk("r1_q0", 32'(bus16.adc_data_q0), 32'h0FC1);
        chk("r1_i1q1", {8'h00, bus16.adc_data_i1, bus16.adc_data_q1}, 32'd0);
        chk("model_r1_q0", 32'(e_q0), 32'h0FC1);

        // 2R2T: mode switch restarts search without counting an error.
        mode = 1'b0; ph = 0;
        clean(49);
        chk("r2_valid", 32'(bus16.adc_valid), 32'd1);
        chk("r2_i0", 32'(bus16.adc_data_i0), 32'h0042);
        chk("r2_q0", 32'(bus16.adc_data_q0), 32'h00C4);
        chk("r2_i1", 32'(bus16.adc_data_i1), 32'h0146);
        chk("r2_q1", 32'(bus16.adc_data_q1), 32'h01C8);
        chk("r2_err", 32'(bus16.adc_err_count), 32'd0);
        chk("model_r2_q1", 32'(e_q1), 32'h01C8);

        // Dropped word while locked in 1R1T.
        mode = 1'b1; ph = 0;
        clean(25);
        chk("pre_slip_locked", 32'(bus16.adc_locked), 32'd1);
        ph = 2;
        clean(2);
        chk("slip_unlock", 32'(bus16.adc_locked), 32'd0);
        chk("slip_err", 32'(bus16.adc_err_count), 32'd1);
        clean(21);
        chk("relock", 32'(bus16.adc_locked), 32'd1);

        // Five more slips with relocks; the 2-bit counter must stick at 3.
        for (int k = 0; k < 5; k++) begin
            ph = 2;
            clean(2);
            clean(21);
        end
        chk("err16_total", 32'(bus16.adc_err_count), 32'd6);
        chk("err2_sat", 32'(bus2.adc_err_count), 32'd3);

        // Mode toggle while locked.
        mode = 1'b0; ph = 0;
        clean(2);
        chk("toggle_unlock", 32'(bus16.adc_locked), 32'd0);
        chk("toggle_err", 32'(bus16.adc_err_count), 32'd6);
        clean(47);
        chk("toggle_relock", 32'(bus16.adc_locked), 32'd1);
        chk("toggle_i1", 32'(bus16.adc_data_i1), 32'h0146);

        // Random 2R2T data with occasional frame glitches and enable drops.
        rand_data = 1;
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 79) != 0);
            send_word((ph < 4) ^ ($urandom_range(0, 49) == 0), 6'($urandom_range(0, 63)));
            ph = (ph + 1) % 8;
        end
        en = 1'b1;
        rand_data = 0;

        // Asynchronous reset mid-period while locked.
        mode = 1'b1; ph = 0;
        clean(25);
        chk("pre_rst_locked", 32'(bus16.adc_locked), 32'd1);
        clean(2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ph = 2;
        clean(18);
        chk("rst_lock_early", 32'(bus16.adc_locked), 32'd0);
        clean(1);
        chk("rst_relock", 32'(bus16.adc_locked), 32'd1);
        clean(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
